// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 adder, with a registered response slot.
// Define FP_ADD_ARB_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins).
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [15:0]           grant_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_idx, sel_idx;
    logic            any_valid, slot_free, grant;

`ifndef FP_ADD_ARB_FIXED_PRIO_EN
    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);
    logic [ID_W:0] scan;
`endif

    // First valid requester found when scanning from ptr (or from 0 in fixed priority)
    always_comb begin
        any_valid = 1'b0;
        gnt_idx   = '0;
`ifndef FP_ADD_ARB_FIXED_PRIO_EN
        scan      = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
            if (!any_valid && req_valid[ID_W'(k)]) begin
                any_valid = 1'b1;
                gnt_idx   = ID_W'(k);
            end
`else
            scan = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan >= NREQ) scan = scan - NREQ;
            if (!any_valid && req_valid[scan[ID_W-1:0]]) begin
                any_valid = 1'b1;
                gnt_idx   = scan[ID_W-1:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL: begin
                if (grant)          state_d = FULL;
                else if (rsp_ready) state_d = EMPTY;
            end
        endcase
    end

    // Reset gating keeps req_ready quiet while rst_n is held low
    always_comb begin
        rsp_valid = (state_q == FULL);
        slot_free = (state_q == EMPTY) || rsp_ready;
        grant     = rst_n && slot_free && any_valid;
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
        sel_idx = grant ? gnt_idx : ptr_q;
        add_a   = req_a[{sel_idx, 5'b0} +: 32];
        add_b   = req_b[{sel_idx, 5'b0} +: 32];
    end

    always_comb begin
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = ptr_q;
        if (grant)
            ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr_q     <= '0;
            grant_cnt <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                rsp_data  <= add_result;
                rsp_id    <= gnt_idx;
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter with a real-arithmetic FP32 adder model.
// Honors FP_ADD_ARB_FIXED_PRIO_EN in the reference arbitration.
module tb_fp_add_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic [31:0]     add_a, add_b, add_result;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic [15:0]     grant_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [33:0] sb[$];
    int          m_ptr;
    logic        m_full;
    logic [15:0] m_cnt;

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic real to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] to_fp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'h0;
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return to_fp(to_real(a) + to_real(b));
    endfunction

    // The shared adder lives in the environment
    always_comb add_result = fp_add(add_a, add_b);

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // Reference model: decides the grant each cycle and queues the expected response
    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_cnt  = '0;
            sb.delete();
        end else begin
            int g;
            logic [N-1:0] exp_ready;
            g = -1;
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
            if (!m_full || rsp_ready) g = pick(req_valid, 0);
`else
            if (!m_full || rsp_ready) g = pick(req_valid, m_ptr);
`endif
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(m_full));
            check("grant_cnt", 64'(grant_cnt), 64'(m_cnt));
            if (g >= 0) begin
                sb.push_back({2'(g), fp_add(req_a[32*g +: 32], req_b[32*g +: 32])});
`ifndef FP_ADD_ARB_FIXED_PRIO_EN
                m_ptr = (g + 1) % N;
`endif
                m_cnt  = m_cnt + 16'd1;
                m_full = 1'b1;
            end else begin
                check("idle_add_a", 64'(add_a), 64'(req_a[32*m_ptr +: 32]));
                if (m_full && rsp_ready) m_full = 1'b0;
            end
        end
    end

    // Monitor: compares the held response against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                check("rsp_id", 64'(rsp_id), 64'(sb[0][33:32]));
                check("rsp_data", 64'(rsp_data), 64'(sb[0][31:0]));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic reset_now();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a2, b2;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #3;
        check("init_rsp_valid", 64'(rsp_valid), 64'd0);
        check("init_grant_cnt", 64'(grant_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request: 1.0 + 2.0
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        @(posedge clk);
        #1;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_id", 64'(rsp_id), 64'd0);
        check("single_data", 64'(rsp_data), 64'h40400000);
        check("single_cnt", 64'(grant_cnt), 64'd1);
        req_valid = '0;

        // All requesters continuously valid
        reset_now();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = rnd_fp();
            req_b[32*i +: 32] = rnd_fp();
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
            check("rr_seq", 64'(req_ready), 64'd1);
`else
            check("rr_seq", 64'(req_ready), 64'(1 << (i % N)));
`endif
            if (i > 0) check("rr_stream_valid", 64'(rsp_valid), 64'd1);
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);

        // Backpressure on requester 2
        #1;
        a2 = rnd_fp();
        b2 = rnd_fp();
        req_a[64 +: 32] = a2;
        req_b[64 +: 32] = b2;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_id", 64'(rsp_id), 64'd2);
            check("bp_data", 64'(rsp_data), 64'(fp_add(a2, b2)));
        end
        @(posedge clk);
        #1;
        a2 = rnd_fp();
        b2 = rnd_fp();
        req_a[64 +: 32] = a2;
        req_b[64 +: 32] = b2;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_grant", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        check("bp_new_valid", 64'(rsp_valid), 64'd1);
        check("bp_new_data", 64'(rsp_data), 64'(fp_add(a2, b2)));
        req_valid = '0;

        // Reset while FULL
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        @(posedge clk);
        #1 req_valid = 4'b1000;
        reset_now();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 64'(rsp_valid), 64'd1);
        check("post_rst_id", 64'(rsp_id), 64'd3);
        check("post_rst_cnt", 64'(grant_cnt), 64'd1);
        req_valid = '0;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = rnd_fp();
                req_b[32*i +: 32] = rnd_fp();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        // Counter wrap after 65536 grants
        #1 req_valid = '0;
        reset_now();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1 req_valid = '0;
        check("wrap_cnt", 64'(grant_cnt), 64'd0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
